// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants for the fetch stage and the downstream opcode decoder:
// default address/instruction widths, the opcode field position, the NOP
// encoding used for pipeline bubbles, and the 5-bit opcode values.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int INSN_W_DEF = 32;

   // Opcode field is always insn[31:27].
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   // All-zero word decodes as r-type "add $0, $0, $0": a harmless bubble.
   localparam logic [INSN_W_DEF-1:0] NOP_INSN = '0;

   typedef enum logic [OPCODE_W-1:0] {
      OP_R    = 5'b00000,
      OP_J    = 5'b00001,
      OP_BNE  = 5'b00010,
      OP_JAL  = 5'b00011,
      OP_JR   = 5'b00100,
      OP_ADDI = 5'b00101,
      OP_BLT  = 5'b00110,
      OP_SW   = 5'b00111,
      OP_LW   = 5'b01000,
      OP_SETX = 5'b10101,
      OP_BEX  = 5'b10110
   } opcode_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles every non-clock signal of the fetch stage.
//   master : the fetch stage itself
//            in : stall, redirect_valid, redirect_pc, imem_data
//            out: imem_addr, ifid_valid, ifid_pc, ifid_insn, ifid_opcode
//   slave  : the surrounding pipeline / ROM / hazard unit (mirror image)
// ---------------------------------------------------------------------------
interface fetch_stage_if
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INSN_W = INSN_W_DEF
) ();

   logic                stall;
   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;
   logic [ADDR_W-1:0]   imem_addr;
   logic [INSN_W-1:0]   imem_data;
   logic                ifid_valid;
   logic [ADDR_W-1:0]   ifid_pc;
   logic [INSN_W-1:0]   ifid_insn;
   logic [OPCODE_W-1:0] ifid_opcode;

   modport master (
      input  stall, redirect_valid, redirect_pc, imem_data,
      output imem_addr, ifid_valid, ifid_pc, ifid_insn, ifid_opcode
   );

   modport slave (
      output stall, redirect_valid, redirect_pc, imem_data,
      input  imem_addr, ifid_valid, ifid_pc, ifid_insn, ifid_opcode
   );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pc_reg
// Program-counter register: async active-low reset to 0, synchronous load
// (highest priority), otherwise increments by one when enabled. Wraps
// naturally modulo 2^W.
//   clock, reset_n : clock / asynchronous active-low reset
//   en             : advance to q+1
//   load           : take load_value (overrides en)
//   load_value     : value to load
//   q              : current PC
// ---------------------------------------------------------------------------
module fetch_stage_pc_reg #(
   parameter int W = 12
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_value;
      end else if (en) begin
         q <= q + W'(1);
      end
   end

endmodule : fetch_stage_pc_reg

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. The PC drives a
// synchronous ROM (1-cycle latency); the returned word is registered into
// IF/ID with a valid bit. Redirects beat stalls, stalls beat normal advance.
//   clock, reset_n : clock / asynchronous active-low reset
//   bus (master)   : stall, redirect_valid/redirect_pc in; imem_addr out,
//                    imem_data in; ifid_valid/ifid_pc/ifid_insn/ifid_opcode out
// ---------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INSN_W = INSN_W_DEF
) (
   input  logic          clock,
   input  logic          reset_n,
   fetch_stage_if.master bus
);

   logic [ADDR_W-1:0] pc;
   logic              f_valid;      // a ROM read is in flight
   logic [ADDR_W-1:0] f_pc;         // address of that in-flight read
   logic              hold_valid;   // hold_insn carries the in-flight word
   logic [INSN_W-1:0] hold_insn;
   logic [INSN_W-1:0] fetched_insn;

   logic              ifid_valid;
   logic [ADDR_W-1:0] ifid_pc;
   logic [INSN_W-1:0] ifid_insn;

   fetch_stage_pc_reg #(.W(ADDR_W)) u_pc_reg (
      .clock      (clock),
      .reset_n    (reset_n),
      .en         (!bus.stall),
      .load       (bus.redirect_valid),
      .load_value (bus.redirect_pc),
      .q          (pc)
   );

   // The ROM keeps reading while stalled, so on the first stall edge its
   // output moves on from the in-flight word (addr f_pc) to the word at pc.
   // That in-flight word is parked in hold_insn and consumed on release.
   always_comb begin
      fetched_insn = bus.imem_data;
      if (hold_valid) begin
         fetched_insn = hold_insn;
      end
   end

   // NOTE: reset clears every register here, including the datapath words,
   // so a bubble after reset is an exact NOP rather than X.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         f_valid    <= 1'b0;
         f_pc       <= '0;
         hold_valid <= 1'b0;
         hold_insn  <= '0;
         ifid_valid <= 1'b0;
         ifid_pc    <= '0;
         ifid_insn  <= NOP_INSN;
      end else if (bus.redirect_valid) begin
         // Squash both the in-flight fetch and the IF/ID word.
         f_valid    <= 1'b0;
         hold_valid <= 1'b0;
         ifid_valid <= 1'b0;
         ifid_insn  <= NOP_INSN;
      end else if (bus.stall) begin
         if (f_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_insn  <= bus.imem_data;
         end
      end else begin
         f_valid    <= 1'b1;
         f_pc       <= pc;
         hold_valid <= 1'b0;
         ifid_valid <= f_valid;
         if (f_valid) begin
            ifid_insn <= fetched_insn;
            ifid_pc   <= f_pc + ADDR_W'(1);
         end else begin
            ifid_insn <= NOP_INSN;
         end
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.ifid_valid  = ifid_valid;
   assign bus.ifid_pc     = ifid_pc;
   assign bus.ifid_insn   = ifid_insn;
   assign bus.ifid_opcode = ifid_insn[OPCODE_MSB:OPCODE_LSB];

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage: synchronous ROM model, reset/latency,
// stall, redirect, redirect+stall, PC wrap and mid-cycle reset.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic clock;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM contents: every word is distinct and carries its own address.
   function automatic logic [31:0] rom_word(input logic [11:0] a);
      return {a[4:0] ^ 5'b10110, 3'b101, a, a};
   endfunction

   // Synchronous ROM, one-cycle read latency.
   always @(posedge clock) bus.imem_data <= rom_word(bus.imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Compare all outputs against an expected IF/ID state.
   task automatic expect_state(input string tag, input logic [11:0] addr,
                               input logic valid, input logic [31:0] insn,
                               input logic [11:0] pc);
      logic [31:0] exp_insn;
      exp_insn = insn;
      check({tag, ".imem_addr"},   32'(bus.imem_addr),   32'(addr));
      check({tag, ".ifid_valid"},  32'(bus.ifid_valid),  32'(valid));
      check({tag, ".ifid_insn"},   bus.ifid_insn,        exp_insn);
      check({tag, ".ifid_pc"},     32'(bus.ifid_pc),     32'(pc));
      check({tag, ".ifid_opcode"}, 32'(bus.ifid_opcode), 32'(exp_insn[31:27]));
   endtask

   // One rising edge; outputs are then sampled at the following falling edge.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      reset_n            = 1'b0;
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      repeat (2) @(negedge clock);
      expect_state("reset", 12'h000, 1'b0, 32'h0, 12'h000);

      // Reset release: first edge is a bubble, second edge holds ROM[0].
      reset_n = 1'b1;
      step(); expect_state("rel_e1", 12'h001, 1'b0, 32'h0, 12'h000);
      step(); expect_state("rel_e2", 12'h002, 1'b1, rom_word(12'h000), 12'h001);
      step(); expect_state("seq_3",  12'h003, 1'b1, rom_word(12'h001), 12'h002);
      step(); expect_state("seq_4",  12'h004, 1'b1, rom_word(12'h002), 12'h003);
      step(); expect_state("seq_5",  12'h005, 1'b1, rom_word(12'h003), 12'h004);

      // Stall three edges at pc=5: everything holds.
      bus.stall = 1'b1;
      step(); expect_state("stall_1", 12'h005, 1'b1, rom_word(12'h003), 12'h004);
      step(); expect_state("stall_2", 12'h005, 1'b1, rom_word(12'h003), 12'h004);
      step(); expect_state("stall_3", 12'h005, 1'b1, rom_word(12'h003), 12'h004);
      bus.stall = 1'b0;
      step(); expect_state("unstall_1", 12'h006, 1'b1, rom_word(12'h004), 12'h005);
      step(); expect_state("unstall_2", 12'h007, 1'b1, rom_word(12'h005), 12'h006);
      step(); expect_state("seq_8",     12'h008, 1'b1, rom_word(12'h006), 12'h007);
      step(); expect_state("seq_9",     12'h009, 1'b1, rom_word(12'h007), 12'h008);

      // Redirect at pc=9 to 0x100: two NOP bubbles then the target word.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 12'h100;
      step(); expect_state("redir_b1", 12'h100, 1'b0, 32'h0, 12'h008);
      bus.redirect_valid = 1'b0;
      step(); expect_state("redir_b2", 12'h101, 1'b0, 32'h0, 12'h008);
      step(); expect_state("redir_tgt", 12'h102, 1'b1, rom_word(12'h100), 12'h101);

      // Redirect together with stall: redirect wins.
      bus.stall          = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 12'h200;
      step(); expect_state("rs_b1", 12'h200, 1'b0, 32'h0, 12'h101);
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      step(); expect_state("rs_b2",  12'h201, 1'b0, 32'h0, 12'h101);
      step(); expect_state("rs_tgt", 12'h202, 1'b1, rom_word(12'h200), 12'h201);

      // PC wrap: jump near the top of the address space.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 12'hFFE;
      step(); expect_state("wrap_b1", 12'hFFE, 1'b0, 32'h0, 12'h201);
      bus.redirect_valid = 1'b0;
      step(); expect_state("wrap_b2", 12'hFFF, 1'b0, 32'h0, 12'h201);
      step(); expect_state("wrap_ffe", 12'h000, 1'b1, rom_word(12'hFFE), 12'hFFF);
      step(); expect_state("wrap_fff", 12'h001, 1'b1, rom_word(12'hFFF), 12'h000);
      step(); expect_state("wrap_000", 12'h002, 1'b1, rom_word(12'h000), 12'h001);

      // Mid-cycle reset: outputs clear before any clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      expect_state("midrst", 12'h000, 1'b0, 32'h0, 12'h000);
      @(negedge clock);
      reset_n = 1'b1;
      step(); expect_state("rerel_e1", 12'h001, 1'b0, 32'h0, 12'h000);
      step(); expect_state("rerel_e2", 12'h002, 1'b1, rom_word(12'h000), 12'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_stage
